// File: rtl/nios_fifo_mailbox_ctrl.sv
// HPS-to-Nios mailbox: a DEPTH x 32 word FIFO with a producer push stream and an
// Avalon-MM slave on the Nios side (pop, status, irq enable, edge capture).
module nios_fifo_mailbox_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              not_empty,
  output logic              full,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_en_q, irq_en_d;
  logic              edge_cap_q, edge_cap_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;
  logic              ne_q, ne_d;

  logic              push_ok, pop_req, pop_ok, wr_en;
  logic [7:0]        cnt8;
  logic [31:0]       status_w;
  logic              unused_wdata;

  // Push handshake: a word transfers on any cycle where push_valid && push_ready;
  // push_ready depends only on registered count, never on push_valid.
  assign not_empty  = (count_q != '0);
  assign full       = (count_q == CNT_FULL);
  assign push_ready = !full;
  assign irq        = edge_cap_q & irq_en_q;
  assign readdata   = readdata_q;

  assign push_ok = push_valid && push_ready;
  assign pop_req = read && (address == 2'd0);
  assign pop_ok  = pop_req && not_empty;
  assign wr_en   = push_ok && !reset;

  assign cnt8     = 8'(count_q);
  assign status_w = {16'b0, cnt8, 4'b0, overflow_q, underflow_q, full, not_empty};

  assign unused_wdata = ^{writedata[31:4], writedata[1]};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    readdata_d  = readdata_q;
    irq_en_d    = irq_en_q;
    edge_cap_d  = edge_cap_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    ne_d        = not_empty;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (read) begin
      case (address)
        2'd0:    readdata_d = pop_ok ? mem[rd_ptr_q] : 32'b0;
        2'd1:    readdata_d = status_w;
        2'd2:    readdata_d = {31'b0, irq_en_q};
        default: readdata_d = {31'b0, edge_cap_q};
      endcase
    end

    // Clears are applied first so a same-cycle set always wins.
    if (write) begin
      case (address)
        2'd1: begin
          if (writedata[2]) underflow_d = 1'b0;
          if (writedata[3]) overflow_d  = 1'b0;
        end
        2'd2:    irq_en_d = writedata[0];
        2'd3:    if (writedata[0]) edge_cap_d = 1'b0;
        default: ;
      endcase
    end

    if (pop_req && !not_empty) underflow_d = 1'b1;
    if (push_valid && full)    overflow_d  = 1'b1;
    if (not_empty && !ne_q)    edge_cap_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      readdata_q  <= '0;
      irq_en_q    <= 1'b0;
      edge_cap_q  <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      ne_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      readdata_q  <= readdata_d;
      irq_en_q    <= irq_en_d;
      edge_cap_q  <= edge_cap_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      ne_q        <= ne_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

endmodule
